// File: rtl/tick_period_checker_if.sv
// Bundle of tick_period_checker control inputs and status outputs.
// Latency: none, wires only.
// Backpressure: none, the checker always accepts ticks.
interface tick_period_checker_if;
    logic       enable;
    logic       tick_in;
    logic       stable_in;
    logic [7:0] expected_cnt;
    logic       clr_err;
    logic       locked;
    logic [8:0] period;
    logic       period_valid;
    logic       err_short;
    logic       err_long;
    logic [7:0] err_cnt;

    // master drives the generator-side inputs and observes status
    modport master (
        output enable, tick_in, stable_in, expected_cnt, clr_err,
        input  locked, period, period_valid, err_short, err_long, err_cnt
    );

    modport slave (
        input  enable, tick_in, stable_in, expected_cnt, clr_err,
        output locked, period, period_valid, err_short, err_long, err_cnt
    );
endinterface

// File: rtl/tick_period_checker.sv
// Measures tick-to-tick distance against the programmed count; reports lock, period and errors.
// Latency: every status output is registered, one edge after the sampled tick cycle.
// Backpressure: none, every tick is consumed in the cycle it arrives.
module tick_period_checker #(
    parameter int LOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    tick_period_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state;
    logic [8:0] gap;
    logic [3:0] good_cnt;
    logic [7:0] exp_reg;
    logic       locked_q;
    logic [8:0] period_q;
    logic       period_valid_q;
    logic       err_short_q;
    logic       err_long_q;
    logic [7:0] err_cnt_q;

    logic [8:0] exp_val;
    logic [8:0] gap_inc;
    logic [3:0] good_inc;
    logic       run;
    logic       exp_chg;
    logic       meas;
    logic       hit_short;
    logic       overdue;
    logic       err_inc;

    always_comb begin
        exp_val   = {1'b0, exp_reg} + 9'd1;
        gap_inc   = (gap == 9'd511) ? gap : gap + 9'd1;
        good_inc  = (good_cnt == LOCK_N) ? good_cnt : good_cnt + 4'd1;
        run       = bus.enable && bus.stable_in;
        exp_chg   = bus.expected_cnt != exp_reg;
        meas      = run && !exp_chg && (state == MEASURE);
        hit_short = meas && bus.tick_in && (gap < exp_val);
        // gap never exceeds exp in MEASURE: reaching exp without a tick leaves the state
        overdue   = meas && !bus.tick_in && (gap == exp_val);
        err_inc   = hit_short || overdue;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            gap            <= 9'd0;
            good_cnt       <= 4'd0;
            exp_reg        <= 8'd0;
            locked_q       <= 1'b0;
            period_q       <= 9'd0;
            period_valid_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
            exp_reg        <= bus.expected_cnt;
            if (!run) begin
                // timebase in transit: drop any tick silently, keep last period
                state    <= IDLE;
                gap      <= 9'd0;
                good_cnt <= 4'd0;
                locked_q <= 1'b0;
            end else if (exp_chg) begin
                state    <= ARM;
                gap      <= 9'd0;
                good_cnt <= 4'd0;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        gap   <= 9'd0;
                    end
                    ARM: begin
                        if (bus.tick_in) begin
                            gap   <= 9'd1;
                            state <= MEASURE;
                        end else begin
                            gap <= gap_inc;
                        end
                    end
                    MEASURE: begin
                        if (bus.tick_in) begin
                            gap            <= 9'd1;
                            period_q       <= gap;
                            period_valid_q <= 1'b1;
                            if (gap < exp_val) begin
                                err_short_q <= 1'b1;
                                good_cnt    <= 4'd0;
                                locked_q    <= 1'b0;
                            end else begin
                                good_cnt <= good_inc;
                                locked_q <= (good_inc == LOCK_N);
                            end
                        end else if (gap == exp_val) begin
                            err_long_q <= 1'b1;
                            good_cnt   <= 4'd0;
                            locked_q   <= 1'b0;
                            gap        <= gap_inc;
                            state      <= ARM;
                        end else begin
                            gap <= gap_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // clear wins over a coincident error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else if (bus.clr_err) begin
            err_cnt_q <= 8'd0;
        end else if (err_inc && (err_cnt_q != 8'd255)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.locked       = locked_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.err_short    = err_short_q;
    assign bus.err_long     = err_long_q;
    assign bus.err_cnt      = err_cnt_q;

    a_err_excl: assert property (@(posedge clk) disable iff (!reset)
        !(err_short_q && err_long_q));
    a_period_nz: assert property (@(posedge clk) disable iff (!reset)
        period_valid_q |-> (period_q != 9'd0));
    a_lock_err: assert property (@(posedge clk) disable iff (!reset)
        (err_short_q || err_long_q) |-> !locked_q);
endmodule

// File: tb/tb_tick_period_checker.sv
// Directed bench for tick_period_checker: vector table plus hand-written corner sequences.
module tb_tick_period_checker;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic err_seen;

    tick_period_checker_if bus ();

    tick_period_checker #(.LOCK_COUNT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       st;
        logic       tk;
        logic [7:0] ec;
        logic       clr;
        logic       lk;
        logic [8:0] per;
        logic       pv;
        logic       es;
        logic       el;
        logic [7:0] errc;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic t);
        bus.tick_in = t;
        step();
        err_seen = err_seen | bus.err_short | bus.err_long;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " locked"}, int'(bus.locked), 0);
        chk({nm, " period"}, int'(bus.period), 0);
        chk({nm, " pv"}, int'(bus.period_valid), 0);
        chk({nm, " es"}, int'(bus.err_short), 0);
        chk({nm, " el"}, int'(bus.err_long), 0);
        chk({nm, " err_cnt"}, int'(bus.err_cnt), 0);
    endtask

    initial begin
        logic [20:0] act_v;
        logic [20:0] exp_v;
        total = 0;
        bad = 0;
        err_seen = 1'b0;

        // exp=3 (expected_cnt=2): lock, short, overdue, ARM tick, stable drop, clear
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 9'd3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 9'd3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 9'd3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 9'd3, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 9'd1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0, 1'b1, 8'd2};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 8'd2};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 8'd2};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 9'd1, 1'b0, 1'b0, 1'b0, 8'd0};

        reset            = 1'b0;
        bus.enable       = 1'b0;
        bus.stable_in    = 1'b0;
        bus.tick_in      = 1'b0;
        bus.expected_cnt = 8'd0;
        bus.clr_err      = 1'b0;
        #12;
        chk_zero("reset");
        reset = 1'b1;
        step();

        for (int i = 0; i < 21; i++) begin
            bus.enable       = tbl[i].en;
            bus.stable_in    = tbl[i].st;
            bus.tick_in      = tbl[i].tk;
            bus.expected_cnt = tbl[i].ec;
            bus.clr_err      = tbl[i].clr;
            step();
            act_v = {bus.locked, bus.period, bus.period_valid, bus.err_short, bus.err_long, bus.err_cnt};
            exp_v = {tbl[i].lk, tbl[i].per, tbl[i].pv, tbl[i].es, tbl[i].el, tbl[i].errc};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL vec%0d: got lk=%0b per=%0d pv=%0b es=%0b el=%0b ec=%0d want lk=%0b per=%0d pv=%0b es=%0b el=%0b ec=%0d",
                         i, bus.locked, bus.period, bus.period_valid, bus.err_short, bus.err_long, bus.err_cnt,
                         tbl[i].lk, tbl[i].per, tbl[i].pv, tbl[i].es, tbl[i].el, tbl[i].errc);
            end
        end
        bus.clr_err = 1'b0;

        // lock at exp=10
        bus.stable_in    = 1'b1;
        bus.expected_cnt = 8'd9;
        cyc(1'b0);
        cyc(1'b1);
        for (int p = 1; p <= 4; p++) begin
            repeat (9) cyc(1'b0);
            chk("s1 pv quiet", int'(bus.period_valid), 0);
            cyc(1'b1);
            chk("s1 pv", int'(bus.period_valid), 1);
            chk("s1 period", int'(bus.period), 10);
            chk("s1 locked", int'(bus.locked), (p == 4) ? 1 : 0);
        end
        chk("s1 err_cnt", int'(bus.err_cnt), 0);

        // early tick 6 cycles after the previous one, then relock
        repeat (5) cyc(1'b0);
        cyc(1'b1);
        chk("s2 es", int'(bus.err_short), 1);
        chk("s2 period", int'(bus.period), 6);
        chk("s2 locked", int'(bus.locked), 0);
        chk("s2 err_cnt", int'(bus.err_cnt), 1);
        for (int p = 1; p <= 4; p++) begin
            repeat (9) cyc(1'b0);
            cyc(1'b1);
            chk("s2 relock", int'(bus.locked), (p == 4) ? 1 : 0);
        end

        // withheld tick
        repeat (9) cyc(1'b0);
        chk("s3 el early", int'(bus.err_long), 0);
        cyc(1'b0);
        chk("s3 el", int'(bus.err_long), 1);
        chk("s3 locked", int'(bus.locked), 0);
        chk("s3 err_cnt", int'(bus.err_cnt), 2);
        repeat (3) cyc(1'b0);
        chk("s3 el once", int'(bus.err_long), 0);
        cyc(1'b1);
        chk("s3 arm pv", int'(bus.period_valid), 0);
        for (int p = 1; p <= 4; p++) begin
            repeat (9) cyc(1'b0);
            cyc(1'b1);
            chk("s3 period", int'(bus.period), 10);
        end
        chk("s3 relock", int'(bus.locked), 1);

        // reprogram 9 -> 4 while locked
        err_seen = 1'b0;
        bus.expected_cnt = 8'd4;
        cyc(1'b0);
        chk("s4 unlock", int'(bus.locked), 0);
        cyc(1'b1);
        chk("s4 arm pv", int'(bus.period_valid), 0);
        for (int p = 1; p <= 4; p++) begin
            repeat (4) cyc(1'b0);
            cyc(1'b1);
            chk("s4 period", int'(bus.period), 5);
            chk("s4 locked", int'(bus.locked), (p == 4) ? 1 : 0);
        end
        chk("s4 no err", int'(err_seen), 0);
        chk("s4 err_cnt", int'(bus.err_cnt), 2);

        // tick every cycle at exp=1
        bus.expected_cnt = 8'd0;
        cyc(1'b1);
        cyc(1'b1);
        for (int c = 1; c <= 6; c++) begin
            cyc(1'b1);
            chk("s5 pv", int'(bus.period_valid), 1);
            chk("s5 period", int'(bus.period), 1);
            chk("s5 locked", int'(bus.locked), (c >= 4) ? 1 : 0);
        end

        // 300 short errors at exp=10
        bus.expected_cnt = 8'd9;
        cyc(1'b1);
        cyc(1'b1);
        repeat (300) cyc(1'b1);
        chk("s6 es", int'(bus.err_short), 1);
        chk("s6 sat", int'(bus.err_cnt), 255);
        bus.clr_err = 1'b1;
        cyc(1'b1);
        chk("s6 clr es", int'(bus.err_short), 1);
        chk("s6 clr", int'(bus.err_cnt), 0);
        bus.clr_err = 1'b0;
        cyc(1'b1);
        chk("s6 inc", int'(bus.err_cnt), 1);
        chk("s6 pre pv", int'(bus.period_valid), 1);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk_zero("s6 arst");
        #3;
        reset = 1'b1;
        bus.tick_in = 1'b0;
        step();
        cyc(1'b1);
        chk("s6 resume arm", int'(bus.period_valid), 0);
        repeat (9) cyc(1'b0);
        cyc(1'b1);
        chk("s6 resume pv", int'(bus.period_valid), 1);
        chk("s6 resume period", int'(bus.period), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
